// File: rtl/wb_stage_pipelined.sv
// Write-back stage: captures one retiring instruction per cycle, waits for DMEM on loads,
// and drives a registered RF write port. Optional retire counter: define WB_RETIRE_CNT_EN.
module wb_stage_pipelined #(
   parameter int DATA_WIDTH = 32,
   parameter int RF_ADDR_W  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MEM_valid_i,
   output logic                  MEM_ready_o,
   input  logic                  MEM_regwrite_i,
   input  logic [RF_ADDR_W-1:0]  MEM_rd_add_i,
   input  logic [DATA_WIDTH-1:0] MEM_pc_i,
   input  logic [DATA_WIDTH-1:0] MEM_imm_i,
   input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
   input  logic [1:0]            MEM_sel_to_reg_i,
   input  logic [2:0]            MEM_funct3_i,
   input  logic                  DMEM_rvalid_i,
   input  logic [DATA_WIDTH-1:0] DMEM_rdata_i,
   output logic                  WB_regwrite_o,
   output logic [RF_ADDR_W-1:0]  WB_rd_add_o,
   output logic [DATA_WIDTH-1:0] WB_data_write_reg_o,
`ifdef WB_RETIRE_CNT_EN
   output logic [63:0]           WB_retire_cnt_o,
`endif
   output logic                  WB_busy_o
);

   // state     | meaning
   // IDLE      | no instruction held, outputs not valid
   // WAIT_LOAD | load captured, waiting for DMEM_rvalid_i
   // COMMIT    | RF write outputs valid for this cycle
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOAD = 2'd1,
      COMMIT    = 2'd2
   } state_t;

   localparam int OFF_W = (DATA_WIDTH == 64) ? 3 : 2;
   localparam logic [1:0] SEL_PC4  = 2'b00;
   localparam logic [1:0] SEL_ALU  = 2'b01;
   localparam logic [1:0] SEL_LOAD = 2'b10;

   state_t state, nxt_state;

   logic                  cap_regwrite;
   logic [RF_ADDR_W-1:0]  cap_rd;
   logic [2:0]            cap_funct3;
   logic [OFF_W-1:0]      cap_off;

   logic                  accept;
   logic                  is_load;
   logic                  do_commit;
   logic                  commit_we;
   logic [RF_ADDR_W-1:0]  commit_rd;
   logic [DATA_WIDTH-1:0] commit_data;
   logic [DATA_WIDTH-1:0] direct_data;

   function automatic logic [DATA_WIDTH-1:0] align_load(
      input logic [DATA_WIDTH-1:0] rdata,
      input logic [OFF_W-1:0]      off,
      input logic [2:0]            f3
   );
      logic [DATA_WIDTH-1:0] b_sh;
      logic [DATA_WIDTH-1:0] h_sh;
      logic [DATA_WIDTH-1:0] w_sh;
      logic [DATA_WIDTH-1:0] res;
      b_sh = rdata >> {off, 3'b000};
      h_sh = rdata >> {off[OFF_W-1:1], 4'b0000};
      // word select only matters for 64-bit; a 32-bit bus already holds one word
      w_sh = (DATA_WIDTH == 64) ? (rdata >> {off[OFF_W-1], 5'b00000}) : rdata;
      case (f3)
         3'b000:  res = DATA_WIDTH'($signed(b_sh[7:0]));
         3'b100:  res = DATA_WIDTH'(b_sh[7:0]);
         3'b001:  res = DATA_WIDTH'($signed(h_sh[15:0]));
         3'b101:  res = DATA_WIDTH'(h_sh[15:0]);
         3'b010:  res = DATA_WIDTH'($signed(w_sh[31:0]));
         3'b110:  res = (DATA_WIDTH == 64) ? DATA_WIDTH'(w_sh[31:0]) : rdata;
         default: res = rdata;
      endcase
      return res;
   endfunction

   assign MEM_ready_o = (state != WAIT_LOAD);
   assign WB_busy_o   = (state == WAIT_LOAD);
   assign accept      = MEM_valid_i & MEM_ready_o;
   assign is_load     = (MEM_sel_to_reg_i == SEL_LOAD);

   always_comb begin
      direct_data = MEM_imm_i;
      case (MEM_sel_to_reg_i)
         SEL_PC4: direct_data = MEM_pc_i + DATA_WIDTH'(4);
         SEL_ALU: direct_data = MEM_alu_result_i;
         default: direct_data = MEM_imm_i;
      endcase
   end

   always_comb begin
      nxt_state   = IDLE;
      do_commit   = 1'b0;
      commit_we   = 1'b0;
      commit_rd   = MEM_rd_add_i;
      commit_data = direct_data;
      case (state)
         WAIT_LOAD: begin
            if (DMEM_rvalid_i) begin
               nxt_state   = COMMIT;
               do_commit   = 1'b1;
               commit_we   = cap_regwrite && (cap_rd != '0);
               commit_rd   = cap_rd;
               commit_data = align_load(DMEM_rdata_i, cap_off, cap_funct3);
            end else begin
               nxt_state = WAIT_LOAD;
            end
         end
         default: begin
            if (accept && is_load) begin
               nxt_state = WAIT_LOAD;
            end else if (accept) begin
               nxt_state = COMMIT;
               do_commit = 1'b1;
               commit_we = MEM_regwrite_i && (MEM_rd_add_i != '0);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= IDLE;
         WB_regwrite_o       <= 1'b0;
         WB_rd_add_o         <= '0;
         WB_data_write_reg_o <= '0;
         cap_regwrite        <= 1'b0;
         cap_rd              <= '0;
         cap_funct3          <= '0;
         cap_off             <= '0;
      end else begin
         state         <= nxt_state;
         WB_regwrite_o <= do_commit & commit_we;
         if (do_commit) begin
            WB_rd_add_o         <= commit_rd;
            WB_data_write_reg_o <= commit_data;
         end
         if (accept && is_load) begin
            cap_regwrite <= MEM_regwrite_i;
            cap_rd       <= MEM_rd_add_i;
            cap_funct3   <= MEM_funct3_i;
            cap_off      <= MEM_alu_result_i[OFF_W-1:0];
         end
      end
   end

`ifdef WB_RETIRE_CNT_EN
   // counts every commit cycle, including suppressed x0 / regwrite=0 writes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         WB_retire_cnt_o <= '0;
      end else if (state == COMMIT) begin
         WB_retire_cnt_o <= WB_retire_cnt_o + 64'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined (32-bit datapath) with hand-computed expectations.
module tb_wb_stage_pipelined;

   logic        clk;
   logic        rst_n;
   logic        MEM_valid_i;
   logic        MEM_ready_o;
   logic        MEM_regwrite_i;
   logic [4:0]  MEM_rd_add_i;
   logic [31:0] MEM_pc_i;
   logic [31:0] MEM_imm_i;
   logic [31:0] MEM_alu_result_i;
   logic [1:0]  MEM_sel_to_reg_i;
   logic [2:0]  MEM_funct3_i;
   logic        DMEM_rvalid_i;
   logic [31:0] DMEM_rdata_i;
   logic        WB_regwrite_o;
   logic [4:0]  WB_rd_add_o;
   logic [31:0] WB_data_write_reg_o;
   logic        WB_busy_o;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] WB_retire_cnt_o;
   logic [63:0] cnt_base;
`endif

   int n_cmp;
   int n_bad;

   wb_stage_pipelined #(.DATA_WIDTH(32), .RF_ADDR_W(5)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .MEM_valid_i         (MEM_valid_i),
      .MEM_ready_o         (MEM_ready_o),
      .MEM_regwrite_i      (MEM_regwrite_i),
      .MEM_rd_add_i        (MEM_rd_add_i),
      .MEM_pc_i            (MEM_pc_i),
      .MEM_imm_i           (MEM_imm_i),
      .MEM_alu_result_i    (MEM_alu_result_i),
      .MEM_sel_to_reg_i    (MEM_sel_to_reg_i),
      .MEM_funct3_i        (MEM_funct3_i),
      .DMEM_rvalid_i       (DMEM_rvalid_i),
      .DMEM_rdata_i        (DMEM_rdata_i),
      .WB_regwrite_o       (WB_regwrite_o),
      .WB_rd_add_o         (WB_rd_add_o),
      .WB_data_write_reg_o (WB_data_write_reg_o),
`ifdef WB_RETIRE_CNT_EN
      .WB_retire_cnt_o     (WB_retire_cnt_o),
`endif
      .WB_busy_o           (WB_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [2:0] f3);
      MEM_valid_i      = 1'b1;
      MEM_sel_to_reg_i = sel;
      MEM_regwrite_i   = rw;
      MEM_rd_add_i     = rd;
      MEM_pc_i         = pc;
      MEM_imm_i        = imm;
      MEM_alu_result_i = alu;
      MEM_funct3_i     = f3;
   endtask

   task automatic expect_wb(input string tag, input logic we, input logic [4:0] rd,
                            input logic [31:0] data);
      check({tag, ".we"},   {63'd0, WB_regwrite_o}, {63'd0, we});
      check({tag, ".rd"},   {59'd0, WB_rd_add_o}, {59'd0, rd});
      check({tag, ".data"}, {32'd0, WB_data_write_reg_o}, {32'd0, data});
   endtask

   // load with a single wait cycle: accept, one WAIT_LOAD cycle with rvalid, then commit
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [31:0] exp_data);
      drive(2'b10, 1'b1, rd, 32'h0, 32'h0, alu, f3);
      tick();
      MEM_valid_i = 1'b0;
      check({tag, ".busy"}, {63'd0, WB_busy_o}, 64'd1);
      DMEM_rvalid_i = 1'b1;
      DMEM_rdata_i  = rdata;
      tick();
      DMEM_rvalid_i = 1'b0;
      expect_wb(tag, 1'b1, rd, exp_data);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      MEM_valid_i = 1'b0;
      MEM_regwrite_i = 1'b0;
      MEM_rd_add_i = '0;
      MEM_pc_i = '0;
      MEM_imm_i = '0;
      MEM_alu_result_i = '0;
      MEM_sel_to_reg_i = '0;
      MEM_funct3_i = '0;
      DMEM_rvalid_i = 1'b0;
      DMEM_rdata_i = '0;
      tick();
      tick();
      expect_wb("reset", 1'b0, 5'd0, 32'h0);
      check("reset.busy",  {63'd0, WB_busy_o}, 64'd0);
      check("reset.ready", {63'd0, MEM_ready_o}, 64'd1);
`ifdef WB_RETIRE_CNT_EN
      check("reset.cnt", WB_retire_cnt_o, 64'd0);
`endif
      rst_n = 1'b1;
      tick();

      // back-to-back non-load ops commit every cycle
      drive(2'b01, 1'b1, 5'd5, 32'h0, 32'h0, 32'h1234, 3'b000);
      tick();
      expect_wb("alu", 1'b1, 5'd5, 32'h1234);
      drive(2'b00, 1'b1, 5'd1, 32'h100, 32'h0, 32'h0, 3'b000);
      tick();
      expect_wb("jal", 1'b1, 5'd1, 32'h104);
      drive(2'b00, 1'b1, 5'd2, 32'hFFFF_FFFC, 32'h0, 32'h0, 3'b000);
      tick();
      expect_wb("jal_wrap", 1'b1, 5'd2, 32'h0);
      drive(2'b11, 1'b1, 5'd3, 32'h0, 32'hDEAD_BEEF, 32'h0, 3'b000);
      tick();
      expect_wb("imm", 1'b1, 5'd3, 32'hDEAD_BEEF);
      MEM_valid_i = 1'b0;
      tick();
      expect_wb("idle_hold", 1'b0, 5'd3, 32'hDEAD_BEEF);

      drive(2'b01, 1'b1, 5'd0, 32'h0, 32'h0, 32'h77, 3'b000);
      tick();
      check("x0.we", {63'd0, WB_regwrite_o}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
      cnt_base = WB_retire_cnt_o;
`endif
      drive(2'b01, 1'b0, 5'd7, 32'h0, 32'h0, 32'h88, 3'b000);
      tick();
      check("norw.we", {63'd0, WB_regwrite_o}, 64'd0);
      MEM_valid_i = 1'b0;
      tick();
`ifdef WB_RETIRE_CNT_EN
      check("cnt.x0_norw", WB_retire_cnt_o, cnt_base + 64'd2);
`endif

      // load stall: rvalid during the accept cycle is ignored, three wait cycles
      drive(2'b10, 1'b1, 5'd9, 32'h0, 32'h0, 32'h2, 3'b000);
      DMEM_rvalid_i = 1'b1;
      DMEM_rdata_i  = 32'h1234_5678;
      tick();
      MEM_valid_i   = 1'b0;
      DMEM_rvalid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall%0d.busy", i),  {63'd0, WB_busy_o}, 64'd1);
         check($sformatf("stall%0d.ready", i), {63'd0, MEM_ready_o}, 64'd0);
         check($sformatf("stall%0d.we", i),    {63'd0, WB_regwrite_o}, 64'd0);
         if (i == 2) begin
            DMEM_rvalid_i = 1'b1;
            DMEM_rdata_i  = 32'h0080_FF00;
            drive(2'b01, 1'b1, 5'd10, 32'h0, 32'h0, 32'h55, 3'b000);
         end
         tick();
      end
      DMEM_rvalid_i = 1'b0;
      expect_wb("lb", 1'b1, 5'd9, 32'hFFFF_FF80);
      check("lb.ready", {63'd0, MEM_ready_o}, 64'd1);
      tick();
      expect_wb("after_load", 1'b1, 5'd10, 32'h55);
      drive(2'b01, 1'b1, 5'd11, 32'h0, 32'h0, 32'h66, 3'b000);
      tick();
      expect_wb("after_load2", 1'b1, 5'd11, 32'h66);
      MEM_valid_i = 1'b0;
      tick();

      do_load("lbu", 3'b100, 32'h2, 5'd12, 32'h0080_FF00, 32'h0000_0080);
      do_load("lhu", 3'b101, 32'h2, 5'd13, 32'h0080_FF00, 32'h0000_0080);
      do_load("lh",  3'b001, 32'h1, 5'd14, 32'h0080_FF00, 32'hFFFF_FF00);
      do_load("lw",  3'b010, 32'h3, 5'd15, 32'h8080_FF00, 32'h8080_FF00);
      do_load("lb3", 3'b000, 32'h3, 5'd16, 32'h7F00_0000, 32'h0000_007F);
      tick();

      // stray rvalid with nothing pending
      DMEM_rvalid_i = 1'b1;
      DMEM_rdata_i  = 32'hAAAA_AAAA;
      tick();
      DMEM_rvalid_i = 1'b0;
      check("stray.we", {63'd0, WB_regwrite_o}, 64'd0);
      check("stray.data", {32'd0, WB_data_write_reg_o}, {32'd0, 32'h7F});

      // reset while a load is pending
      drive(2'b10, 1'b1, 5'd17, 32'h0, 32'h0, 32'h0, 3'b010);
      tick();
      MEM_valid_i = 1'b0;
      check("rstload.busy", {63'd0, WB_busy_o}, 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rstload.ready", {63'd0, MEM_ready_o}, 64'd1);
      check("rstload.busy0", {63'd0, WB_busy_o}, 64'd0);
      DMEM_rvalid_i = 1'b1;
      DMEM_rdata_i  = 32'hCAFE_F00D;
      tick();
      DMEM_rvalid_i = 1'b0;
      expect_wb("rstload", 1'b0, 5'd0, 32'h0);
      check("rstload.ready2", {63'd0, MEM_ready_o}, 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
